fifo_param: RTL and testbench

Parametrised synchronous FIFO for byte- or word-stream buffering between producer and consumer blocks sharing one clock. It replaces fixed 8-bit x 32 FIFOs with configurable width and depth. It adds an occupancy count, programmable almost-full and almost-empty thresholds, overflow/underflow error pulses, a read-data valid strobe, and an asynchronous active-low reset. Full-state read+write is accepted in the same cycle, so throughput is sustained at full occupancy.

---
 rtl/fifo_param_pkg.sv | 11 +
 rtl/fifo_ram.sv | 39 +++
 rtl/fifo_param.sv | 95 +++++++++
 tb/tb_fifo_param.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fifo_param_pkg.sv
// Shared defaults for the parametrised FIFO family: data/address widths and
// almost-full/almost-empty thresholds reused by other FIFO variants.
package fifo_param_pkg;

   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_ADDR_W    = 5;
   localparam int unsigned DEF_AF_LEVEL  = 28;
   localparam int unsigned DEF_AE_LEVEL  = 4;
   localparam int unsigned DEF_HOLD_DATA = 0;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array: synchronous write port and registered read
// port. The read register holds its value when no read is requested.
module fifo_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Storage is deliberately left unreset.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable thresholds,
// overflow/underflow pulses and a read-data valid strobe.
module fifo_param
   import fifo_param_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned AF_LEVEL  = DEF_AF_LEVEL,
   parameter int unsigned AE_LEVEL  = DEF_AE_LEVEL,
   parameter int unsigned HOLD_DATA = DEF_HOLD_DATA
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              write,
   input  logic [DATA_W-1:0] datain,
   input  logic              read,
   output logic [DATA_W-1:0] dataout,
   output logic              dout_valid,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_CNT  = (ADDR_W + 1)'(AE_LEVEL);

   logic [ADDR_W:0]   wptr_q, rptr_q, count_q, count_d;
   logic              dout_valid_q, overflow_q, underflow_q;
   logic              rd_en, wr_en;
   logic [DATA_W-1:0] ram_rdata;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                  (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

   // A write into a full FIFO is fine as long as a read frees a slot this cycle.
   assign rd_en = read & ~empty;
   assign wr_en = write & (~full | rd_en);

   always_comb begin
      count_d = count_q;
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + PTR_ONE;
         2'b01:   count_d = count_q - PTR_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wptr_q       <= '0;
         rptr_q       <= '0;
         count_q      <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + PTR_ONE;
         if (rd_en) rptr_q <= rptr_q + PTR_ONE;
         count_q      <= count_d;
         dout_valid_q <= rd_en;
         overflow_q   <= write & ~wr_en;
         underflow_q  <= read & ~rd_en;
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clock   (clock),
      .reset_n (reset_n),
      .we      (wr_en),
      .waddr   (wptr_q[ADDR_W-1:0]),
      .wdata   (datain),
      .re      (rd_en),
      .raddr   (rptr_q[ADDR_W-1:0]),
      .rdata   (ram_rdata)
   );

   // Legacy mode zeroes the output in cycles that carry no fresh read.
   assign dataout      = (HOLD_DATA != 0 || dout_valid_q) ? ram_rdata : '0;
   assign dout_valid   = dout_valid_q;
   assign count        = count_q;
   assign almost_full  = (count_q >= AF_CNT);
   assign almost_empty = (count_q <= AE_CNT);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: directed test-plan steps plus random
// traffic, compared against a queue-based reference model.
module tb_fifo_param;

   localparam int DEPTH = 32;
   localparam int AF    = 28;
   localparam int AE    = 4;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       write = 1'b0;
   logic [7:0] datain = 8'h00;
   logic       read = 1'b0;
   logic [7:0] dataout;
   logic       dout_valid, full, empty, almost_full, almost_empty;
   logic [5:0] count;
   logic       overflow, underflow;

   int errors = 0;
   int checks = 0;

   logic [7:0] q[$];
   logic       exp_valid, exp_ovf, exp_unf;
   logic [7:0] exp_dout;

   fifo_param dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .write        (write),
      .datain       (datain),
      .read         (read),
      .dataout      (dataout),
      .dout_valid   (dout_valid),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      chk({tag, ".count"}, 32'(count), n);
      chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
      chk({tag, ".full"}, 32'(full), 32'(n == DEPTH));
      chk({tag, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
      chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(exp_valid));
      chk({tag, ".dataout"}, 32'(dataout), 32'(exp_dout));
      chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
      chk({tag, ".underflow"}, 32'(underflow), 32'(exp_unf));
   endtask

   // One clock of traffic; the model decides acceptance from occupancy alone.
   task automatic step(input string tag, input logic w, input logic [7:0] d, input logic r);
      bit ra, wa;
      logic [7:0] popped;
      write  = w;
      datain = d;
      read   = r;
      ra = r && (q.size() > 0);
      wa = w && ((q.size() < DEPTH) || ra);
      popped = 8'h00;
      if (ra) popped = q.pop_front();
      if (wa) q.push_back(d);
      @(posedge clock);
      #1;
      exp_valid = ra;
      exp_dout  = ra ? popped : 8'h00;
      exp_ovf   = w && !wa;
      exp_unf   = r && !ra;
      write = 1'b0;
      read  = 1'b0;
      check_all(tag);
   endtask

   initial begin
      exp_valid = 1'b0;
      exp_dout  = 8'h00;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;

      #12;
      check_all("reset");
      @(negedge clock);
      reset_n = 1'b1;

      for (int i = 1; i <= 32; i++) step("fill", 1'b1, 8'(i), 1'b0);
      step("ovf_write", 1'b1, 8'hAA, 1'b0);
      step("ovf_clear", 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 32; i++) step("drain", 1'b0, 8'h00, 1'b1);
      step("idle_empty", 1'b0, 8'h00, 1'b0);

      for (int i = 1; i <= 32; i++) step("refill", 1'b1, 8'(i + 100), 1'b0);
      step("full_rw", 1'b1, 8'h55, 1'b1);
      for (int i = 0; i < 32; i++) step("drain55", 1'b0, 8'h00, 1'b1);

      step("empty_rw", 1'b1, 8'h33, 1'b1);
      step("read33", 1'b0, 8'h00, 1'b1);

      for (int i = 0; i < 3; i++) step("prime", 1'b1, 8'(i), 1'b0);
      for (int i = 3; i < 203; i++) step("stream", 1'b1, 8'(i), 1'b1);

      for (int i = 0; i < 400; i++) begin
         logic w, r;
         w = ($urandom_range(0, 99) < 55);
         r = ($urandom_range(0, 99) < 45);
         if (i >= 200) begin
            w = ($urandom_range(0, 99) < 40);
            r = ($urandom_range(0, 99) < 60);
         end
         step("random", w, 8'($urandom), r);
      end

      for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(i + 200), 1'b1);
      #3;
      reset_n = 1'b0;
      #1;
      q.delete();
      exp_valid = 1'b0;
      exp_dout  = 8'h00;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
      check_all("mid_reset");
      @(negedge clock);
      reset_n = 1'b1;
      step("post_rst_wr", 1'b1, 8'hC3, 1'b0);
      step("post_rst_rd", 1'b0, 8'h00, 1'b1);
      step("post_rst_idle", 1'b0, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
